// File: rtl/fb_rd_stream.sv
// rtl/fb_rd_stream.sv - frame-buffer scan-out reader with 2-entry skid buffer (optional FB_RD_LINE_MARKER_EN)
module fb_rd_stream #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3,
    parameter int FRAME_LEN  = 8,
    parameter int LINE_LEN   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
`ifdef FB_RD_LINE_MARKER_EN
    output logic                  out_sol,
    output logic                  out_eol,
`endif
    output logic                  out_sof,
    output logic                  out_eof
);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(FRAME_LEN - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  inflight_q, inflight_d;
    logic [ADDR_WIDTH-1:0] fl_idx_q, fl_idx_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] buf_data_q [2];
    logic [DATA_WIDTH-1:0] buf_data_d [2];
    logic [ADDR_WIDTH-1:0] buf_idx_q [2];
    logic [ADDR_WIDTH-1:0] buf_idx_d [2];
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            occ_q, occ_d;

    logic                  push, pop, issue;
    logic [2:0]            used;
    logic [ADDR_WIDTH-1:0] head_idx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            base_q     <= '0;
            cnt_q      <= '0;
            inflight_q <= 1'b0;
            fl_idx_q   <= '0;
            done_q     <= 1'b0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            occ_q      <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                buf_data_q[i] <= '0;
                buf_idx_q[i]  <= '0;
            end
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            cnt_q      <= cnt_d;
            inflight_q <= inflight_d;
            fl_idx_q   <= fl_idx_d;
            done_q     <= done_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            for (int i = 0; i < 2; i++) begin
                buf_data_q[i] <= buf_data_d[i];
                buf_idx_q[i]  <= buf_idx_d[i];
            end
        end
    end

    // A read may issue only if its returning word is sure to find a free slot,
    // counting the word leaving the buffer this cycle.
    always_comb begin
        pop   = out_valid & out_ready;
        push  = inflight_q;
        used  = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue = (state_q == RUN) && (used <= 3'd1);
    end

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d  = base_addr;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (issue) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_IDX) state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Leave on the edge that removes the final word so done lines up with it.
                if (!inflight_q && (occ_q - {1'b0, pop}) == 2'd0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        inflight_d = issue;
        fl_idx_d   = issue ? cnt_q : fl_idx_q;
        buf_data_d = buf_data_q;
        buf_idx_d  = buf_idx_q;
        if (push) begin
            buf_data_d[wr_ptr_q] = mem_rd_data;
            buf_idx_d[wr_ptr_q]  = fl_idx_q;
        end
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        occ_d    = occ_q + {1'b0, push} - {1'b0, pop};
    end

    always_comb begin
        busy        = (state_q != IDLE);
        done        = done_q;
        mem_rd_en   = issue;
        mem_rd_addr = base_q + cnt_q;
        out_valid   = (occ_q != 2'd0);
        out_data    = buf_data_q[rd_ptr_q];
        head_idx    = buf_idx_q[rd_ptr_q];
        out_sof     = out_valid && (head_idx == '0);
        out_eof     = out_valid && (head_idx == LAST_IDX);
`ifdef FB_RD_LINE_MARKER_EN
        out_sol     = out_valid && ((int'(head_idx) % LINE_LEN) == 0);
        out_eol     = out_valid && ((int'(head_idx) % LINE_LEN) == LINE_LEN - 1);
`endif
    end
endmodule
